joy_serial_scanner: RTL

- Parametrised scanner for an external parallel-in/serial-out shift-register chain (74x165-style) that carries joystick and button lines.
- Generates the shift clock and the active-low load strobe, and deserialises NBITS per frame.
- Optionally inverts the data and optionally filters it, publishing only frames that match the previous frame.
- Sits between the board joystick pins and the core's input mapping; it raises a one-cycle strobe on every published frame.

---
 rtl/joy_serial_scanner.sv | 92 +++++++++
 1 files changed

// File: rtl/joy_serial_scanner.sv
// joy_serial_scanner: drives a 74x165-style chain and publishes deserialised, optionally filtered frames.
module joy_serial_scanner #(
  parameter int NBITS       = 16,
  parameter int HALF_PERIOD = 128,
  parameter int LOAD_CYCLES = 1,
  parameter bit INVERT      = 1'b0,
  parameter bit FILTER      = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             joy_data,
  output logic             joy_clk,
  output logic             joy_load_n,
  output logic [NBITS-1:0] buttons,
  output logic             frame_strobe,
  output logic             changed
);
  localparam int DW = $clog2(HALF_PERIOD);
  localparam int IW = $clog2(NBITS);
  localparam logic [NBITS-1:0] RELEASED = INVERT ? '0 : '1;
  localparam logic [2:0] LMAX = 3'(LOAD_CYCLES - 1);
  typedef enum logic {LOAD, SHIFT} state_t;
  state_t           state_q, state_d;
  logic [DW-1:0]    div_q, div_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [2:0]       lcnt_q, lcnt_d;
  logic             jclk_q, jclk_d, load_n_q, load_n_d, pend_q, pend_d;
  logic             strobe_q, strobe_d, chg_q, chg_d;
  logic [NBITS-1:0] cap_q, cap_d, btn_q, btn_d, prev_q, prev_d;
  logic [NBITS-1:0] cap_full, cand;
  logic             tick, rise, fall, sample, last, go_shift, go_load, pub;
  always_comb begin
    tick     = div_q == DW'(HALF_PERIOD - 1);
    rise     = tick & ~jclk_q;
    fall     = tick & jclk_q;
    sample   = state_q == SHIFT && rise;
    last     = sample && idx_q == IW'(NBITS - 1);
    go_shift = state_q == LOAD && fall && lcnt_q == LMAX;
    go_load  = state_q == SHIFT && fall && pend_q;
    cap_full = cap_q;
    cap_full[idx_q] = joy_data;
    cand     = INVERT ? ~cap_full : cap_full;
    pub      = last && (!FILTER || cand == prev_q);
    div_d    = tick ? '0 : div_q + 1'b1;
    jclk_d   = jclk_q ^ tick;
    state_d  = go_shift ? SHIFT : go_load ? LOAD : state_q;
    load_n_d = go_shift ? 1'b1 : go_load ? 1'b0 : load_n_q;
    lcnt_d   = go_load ? '0 : (state_q == LOAD && fall) ? lcnt_q + 1'b1 : lcnt_q;
    idx_d    = go_shift ? '0 : sample ? idx_q + 1'b1 : idx_q;
    pend_d   = go_load ? 1'b0 : last ? 1'b1 : pend_q;
    cap_d    = sample ? cap_full : cap_q;
    // the final bit is merged combinationally so the frame publishes one clk after its last rise
    strobe_d = pub;
    chg_d    = pub && cand != btn_q;
    btn_d    = pub ? cand : btn_q;
    prev_d   = last ? cand : prev_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= LOAD;
      div_q    <= '0;
      jclk_q   <= 1'b0;
      load_n_q <= 1'b0;
      idx_q    <= '0;
      lcnt_q   <= '0;
      pend_q   <= 1'b0;
      cap_q    <= '0;
      btn_q    <= RELEASED;
      prev_q   <= RELEASED;
      strobe_q <= 1'b0;
      chg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      jclk_q   <= jclk_d;
      load_n_q <= load_n_d;
      idx_q    <= idx_d;
      lcnt_q   <= lcnt_d;
      pend_q   <= pend_d;
      cap_q    <= cap_d;
      btn_q    <= btn_d;
      prev_q   <= prev_d;
      strobe_q <= strobe_d;
      chg_q    <= chg_d;
    end
  end
  assign joy_clk      = jclk_q;
  assign joy_load_n   = load_n_q;
  assign buttons      = btn_q;
  assign frame_strobe = strobe_q;
  assign changed      = chg_q;
endmodule
